// File: rtl/exp_horner_seq.sv
// rtl/exp_horner_seq.sv - sequential Horner exp(x) evaluator on one shared multiplier/adder
//
// Purpose:
//   Evaluates exp(x) as the 5th-order Taylor polynomial
//     y = A0 + x*(A1 + x*(A2 + x*(A3 + x*(A4 + x*A5)))).
//   One multiplier and one adder are reused for all five Horner steps.
//   A small FSM sequences them, giving one result per 12 cycles at best.
//   x is unsigned Q2.14. The accumulator and the result are Q7.25.
//
// Ports:
//   clk      in   1         single clock, rising edge
//   reset    in   1         synchronous, active-high
//   i_valid  in   1         i_x is valid
//   o_ready  out  1         block can accept i_x (high only in IDLE)
//   i_x      in   WIDTHIN   unsigned Q2.14 operand
//   o_valid  out  1         o_y holds a finished result
//   i_ready  in   1         downstream accepts o_y
//   o_y      out  WIDTHOUT  Q7.25 result, modulo 2^WIDTHOUT
//
// Configuration macro:
//   ROUND_EN  when defined, the product is rounded half-up at the truncation point.
//             When undefined, the product is plainly truncated.

module exp_horner_seq #(
  parameter int                 WIDTHIN  = 16,
  parameter int                 WIDTHOUT = 32,
  parameter logic [WIDTHIN-1:0] A0       = 16'h4000,
  parameter logic [WIDTHIN-1:0] A1       = 16'h4000,
  parameter logic [WIDTHIN-1:0] A2       = 16'h2000,
  parameter logic [WIDTHIN-1:0] A3       = 16'h0AAA,
  parameter logic [WIDTHIN-1:0] A4       = 16'h02AA,
  parameter logic [WIDTHIN-1:0] A5       = 16'h0088
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [WIDTHIN-1:0]  i_x,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [WIDTHOUT-1:0] o_y
);

  // Fraction bits of x (Q2.14) and of the accumulator (Q7.25).
  localparam int FRAC_IN  = WIDTHIN - 2;
  localparam int FRAC_OUT = WIDTHOUT - 7;
  // Shift that places a Q2.14 coefficient onto the Q7.25 grid.
  localparam int ALIGN    = FRAC_OUT - FRAC_IN;
  localparam int PW       = WIDTHIN + WIDTHOUT;
  localparam logic [2:0] LAST_ITER = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_ADD  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [2:0]          iter;
  logic [WIDTHOUT-1:0] acc;
  logic [WIDTHOUT-1:0] prod;
  logic [WIDTHIN-1:0]  x_q;

  logic [WIDTHIN-1:0]  coef;
  logic [WIDTHOUT-1:0] coef_term;
  logic [WIDTHOUT-1:0] a5_term;
  logic [PW-1:0]       p_full;
  logic [WIDTHOUT-1:0] mul_res;
  logic                accept;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (i_valid)            state_next = S_MUL;
      S_MUL:                          state_next = S_ADD;
      S_ADD:  if (iter == LAST_ITER)  state_next = S_DONE;
              else                    state_next = S_MUL;
      S_DONE: if (i_ready)            state_next = S_IDLE;
      default:                        state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    o_ready = 1'b0;
    o_valid = 1'b0;
    case (state)
      S_IDLE:  o_ready = 1'b1;
      S_DONE:  o_valid = 1'b1;
      default: begin
        o_ready = 1'b0;
        o_valid = 1'b0;
      end
    endcase
  end

  // o_y follows acc at all times. acc only changes in IDLE/MUL/ADD, so the
  // result holds steady while DONE waits for i_ready.
  assign o_y = acc;

  assign accept = (state == S_IDLE) && i_valid;

  // ---------------------------------------------------------------------------
  // Shared datapath
  // ---------------------------------------------------------------------------

  // Coefficient added after the iter-th multiply: A4 first, down to A0.
  always_comb begin
    coef = A0;
    case (iter)
      3'd0:    coef = A4;
      3'd1:    coef = A3;
      3'd2:    coef = A2;
      3'd3:    coef = A1;
      default: coef = A0;
    endcase
  end

  assign coef_term = WIDTHOUT'(coef) << ALIGN;
  assign a5_term   = WIDTHOUT'(A5) << ALIGN;

  // Q7.25 * Q2.14 gives a Q9.39 product. Dropping FRAC_IN low bits returns it
  // to Q7.25. The two top integer bits fall off, so the product wraps instead
  // of saturating.
  assign p_full = PW'(acc) * PW'(x_q);

`ifdef ROUND_EN
  assign mul_res = WIDTHOUT'((p_full + PW'(1 << (FRAC_IN - 1))) >> FRAC_IN);
`else
  assign mul_res = WIDTHOUT'(p_full >> FRAC_IN);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      iter <= 3'd0;
      acc  <= '0;
      prod <= '0;
      x_q  <= '0;
    end else begin
      if (accept) begin
        x_q  <= i_x;
        acc  <= a5_term;
        iter <= 3'd0;
      end
      if (state == S_MUL) begin
        prod <= mul_res;
      end
      if (state == S_ADD) begin
        // Carry out of the adder is discarded; the sum wraps modulo 2^WIDTHOUT.
        acc <= prod + coef_term;
        if (iter != LAST_ITER) begin
          iter <= iter + 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_exp_horner_seq.sv
// tb/tb_exp_horner_seq.sv - directed and random checks for exp_horner_seq

module tb_exp_horner_seq;

  logic        clk;
  logic        reset;
  logic        i_valid;
  logic        o_ready;
  logic [15:0] i_x;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_y;

  int n_checks = 0;
  int n_errors = 0;

  exp_horner_seq dut (
    .clk     (clk),
    .reset   (reset),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_x     (i_x),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_y     (o_y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
    n_checks++;
    if (got !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp_v);
    end
  endtask

  // Bit-accurate reference for the build being simulated.
  function automatic logic [31:0] mulq(input logic [31:0] a, input logic [15:0] b);
    logic [47:0] p;
    p = {16'b0, a} * {32'b0, b};
`ifdef ROUND_EN
    p = p + 48'h2000;
`endif
    return p[45:14];
  endfunction

  function automatic logic [31:0] horner(input logic [15:0] x);
    logic [15:0] coefs [5];
    logic [31:0] acc;
    coefs = '{16'h02AA, 16'h0AAA, 16'h2000, 16'h4000, 16'h4000};
    acc = {5'b0, 16'h0088, 11'b0};
    for (int i = 0; i < 5; i++) begin
      acc = mulq(acc, x) + {5'b0, coefs[i], 11'b0};
    end
    return acc;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transaction with i_ready held high. Optionally checks the latency
  // from acceptance to o_valid and the return to IDLE.
  task automatic run_one(input logic [15:0] x, input logic [31:0] exp_y,
                         input string tag, input bit full);
    int n;
    int k;
    n = 0;
    while (!o_ready && n < 30) begin
      tick();
      n++;
    end
    i_valid = 1'b1;
    i_x     = x;
    tick();
    i_valid = 1'b0;
    if (full) check({tag, "_busy_ready"}, 32'(o_ready), 32'd0);
    k = 0;
    while (!o_valid && k < 20) begin
      tick();
      k++;
    end
    if (full) check({tag, "_latency"}, 32'(k), 32'd10);
    check({tag, "_y"}, o_y, exp_y);
    tick();
    if (full) begin
      check({tag, "_idle_ready"}, 32'(o_ready), 32'd1);
      check({tag, "_idle_valid"}, 32'(o_valid), 32'd0);
    end
  endtask

  initial begin : main
    logic [31:0] held_y;
    logic [15:0] rx;
    int          k;
    int          accepts;
    int          acc_cyc [2];
    int          cyc;
    logic [31:0] results [$];
    bit          acc_now;
    bit          out_now;

    reset   = 1'b1;
    i_valid = 1'b0;
    i_ready = 1'b1;
    i_x     = 16'h0000;
    tick();
    tick();
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_ready", 32'(o_ready), 32'd1);
    check("rst_y",     o_y,          32'd0);
    reset = 1'b0;

    run_one(16'h0000, 32'h0200_0000, "x0",   1'b1);
    run_one(16'h4000, 32'h056E_E000, "x1p0", 1'b1);
    run_one(16'h8000, 32'h0E87_8000, "x2p0", 1'b1);

    // Backpressure: i_ready low for the first 5 DONE cycles.
    i_ready = 1'b0;
    i_valid = 1'b1;
    i_x     = 16'h4000;
    tick();
    i_valid = 1'b0;
    k = 0;
    while (!o_valid && k < 20) begin
      tick();
      k++;
    end
    check("bp_latency", 32'(k), 32'd10);
    held_y = o_y;
    check("bp_y", held_y, 32'h056E_E000);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("bp_hold_valid", 32'(o_valid), 32'd1);
      check("bp_hold_y",     o_y,          held_y);
      check("bp_hold_ready", 32'(o_ready), 32'd0);
    end
    i_ready = 1'b1;
    tick();
    check("bp_release_ready", 32'(o_ready), 32'd1);
    check("bp_release_valid", 32'(o_valid), 32'd0);

    // i_valid held high across two transactions.
    i_valid = 1'b1;
    i_x     = 16'h4000;
    accepts = 0;
    cyc     = 0;
    while ((accepts < 2 || results.size() < 2) && cyc < 60) begin
      acc_now = o_ready && i_valid;
      out_now = o_valid && i_ready;
      if (out_now) results.push_back(o_y);
      tick();
      cyc++;
      if (acc_now) begin
        acc_cyc[accepts] = cyc;
        accepts++;
        i_x = 16'h0000;
        if (accepts == 2) i_valid = 1'b0;
      end
    end
    i_valid = 1'b0;
    check("stream_accepts", 32'(accepts), 32'd2);
    check("stream_gap", 32'(acc_cyc[1] - acc_cyc[0]), 32'd12);
    check("stream_nres", 32'(results.size()), 32'd2);
    if (results.size() == 2) begin
      check("stream_y0", results[0], 32'h056E_E000);
      check("stream_y1", results[1], 32'h0200_0000);
    end
    // The loop exits on the edge that completes the second handshake.
    check("stream_idle", 32'(o_ready), 32'd1);

    // Reset during MUL of iter 2, with i_valid also asserted under reset.
    i_valid = 1'b1;
    i_x     = 16'h4000;
    tick();
    i_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    reset   = 1'b1;
    i_valid = 1'b1;
    tick();
    check("midrst_valid", 32'(o_valid), 32'd0);
    check("midrst_ready", 32'(o_ready), 32'd1);
    tick();
    check("rst_wins_ready", 32'(o_ready), 32'd1);
    reset   = 1'b0;
    i_valid = 1'b0;
    run_one(16'h0000, 32'h0200_0000, "after_rst", 1'b1);

    // Random operands against the reference model.
    for (int i = 0; i < 500; i++) begin
      rx = 16'($urandom);
      run_one(rx, horner(rx), "rand", 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
